stall_bubble_controller: RTL and testbench
==========================================

STALL_BUBBLE_CONTROLLER -- requirements
Module: stall_bubble_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of the writeback data path and the forward-capture register.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port enable_bubble  input  1  load-use stall request from the load-use hazard unit.
REQ-005 The block SHALL have ports enable_rs1_forward_from_wb and enable_rs2_forward_from_wb  input  1 each  per-operand forward-from-WB requests.
REQ-006 The block SHALL have port data_mem_busy  input  1  data memory not ready; the whole pipe must freeze.
REQ-007 The block SHALL have port branch_taken  input  1  control redirect from EX; younger instructions must be flushed.
REQ-008 The block SHALL have port wb_write_data  input  DATA_WIDTH  result present in the WB stage.
REQ-009 The block SHALL have ports pc_write_en and ifid_write_en  output  1 each  1 = PC / IF-ID register advances.
REQ-010 The block SHALL have port pipe_hold  output  1  1 = ID-EX, EX-MEM and MEM-WB hold their contents.
REQ-011 The block SHALL have ports ifid_flush and idex_bubble  output  1 each  1 = insert NOP into IF-ID / ID-EX.
REQ-012 The block SHALL have ports rs1_fwd_sel and rs2_fwd_sel  output  1 each  1 = EX operand takes fwd_data.
REQ-013 The block SHALL have port fwd_data  output  DATA_WIDTH  captured WB load result.

Function
REQ-014 The FSM SHALL use states RUN, LOAD_STALL, FWD, MEM_WAIT and FLUSH; all outputs are Moore, decoded from the registered state and registers only.
REQ-015 Requests sampled at rising edge N SHALL take effect on outputs from edge N onward, giving a 1-cycle response latency.
REQ-016 Priority at every sample SHALL be data_mem_busy > branch_taken > enable_bubble.
REQ-017 In RUN: pc_write_en=1, ifid_write_en=1, all other control outputs 0.
REQ-018 From RUN: data_mem_busy -> MEM_WAIT; else branch_taken -> FLUSH; else enable_bubble -> LOAD_STALL; else stay in RUN.
REQ-019 LOAD_STALL lasts exactly 1 cycle: pc_write_en=0, ifid_write_en=0, idex_bubble=1; the rs1/rs2 forward requests are latched on entry.
REQ-020 On the LOAD_STALL -> FWD edge, fwd_data SHALL capture wb_write_data.
REQ-021 FWD lasts exactly 1 cycle: rs1_fwd_sel and rs2_fwd_sel equal the latched requests; pc_write_en=1 and ifid_write_en=1; then apply the RUN transition rules.
REQ-022 If data_mem_busy is sampled in LOAD_STALL or FWD, the block SHALL go to MEM_WAIT, keeping the latched forward selects and fwd_data, and return to the interrupted state when busy clears.
REQ-023 In MEM_WAIT: pc_write_en=0, ifid_write_en=0, pipe_hold=1, idex_bubble=0; it exits the first cycle data_mem_busy is sampled 0.
REQ-024 FLUSH lasts exactly 1 cycle: ifid_flush=1 and idex_bubble=1, PC writes enabled; branch_taken overrides a simultaneous enable_bubble, which is dropped.
REQ-025 rs1_fwd_sel and rs2_fwd_sel SHALL be 0 in every state except FWD.
REQ-026 Forward selects SHALL be 0 in FWD if the corresponding request was 0 at LOAD_STALL entry, even if enable_bubble was 1.
REQ-027 Unknown or illegal state encodings SHALL recover to RUN on the next edge.

Reset
REQ-028 While reset=1 at an edge: state=RUN, pc_write_en=1, ifid_write_en=1, all other outputs 0, fwd_data=0, latched selects 0.
REQ-029 Reset asserted mid-stall (LOAD_STALL, FWD, MEM_WAIT, FLUSH) SHALL abandon the operation with no residual forward or bubble.

Configuration
REQ-030 Macro STALL_COUNTER_EN SHALL add output stall_cycles (32 bits), which increments in every cycle with pc_write_en=0, wraps at 2^32-1 -> 0, and resets to 0.
REQ-031 Without STALL_COUNTER_EN, the port and the counter SHALL be absent and all other behaviour identical.

Verification
REQ-032 Reset held 2 cycles, then released with all inputs 0 -> pc_write_en=1, ifid_write_en=1, all others 0, fwd_data=0.
REQ-033 enable_bubble=1 and rs2 request=1 for 1 cycle, wb_write_data=0xDEADBEEF during LOAD_STALL -> 1 cycle with idex_bubble=1 and pc_write_en=0, then 1 cycle with rs2_fwd_sel=1, rs1_fwd_sel=0, fwd_data=0xDEADBEEF.
REQ-034 branch_taken=1 and enable_bubble=1 sampled in the same cycle -> FLUSH for 1 cycle (ifid_flush=1), no LOAD_STALL, forward selects 0.
REQ-035 data_mem_busy=1 for 3 cycles starting in LOAD_STALL -> pipe_hold=1 for 3 cycles, then LOAD_STALL completes and FWD uses the preserved selects.
REQ-036 reset=1 during MEM_WAIT -> RUN outputs on the next edge; with STALL_COUNTER_EN, stall_cycles=0.
REQ-037 With STALL_COUNTER_EN, preload the counter near 0xFFFFFFFF and run 2 stall cycles -> value wraps to 0x00000000.

Source files
------------

// File: rtl/stall_bubble_controller.sv
// stall_bubble_controller: sequences load-use stalls, WB forwarding, memory freezes and branch flushes.
// Optional macro STALL_COUNTER_EN adds a 32-bit stall_cycles output counting cycles with the PC frozen.
module stall_bubble_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_bubble,
    input  logic                  enable_rs1_forward_from_wb,
    input  logic                  enable_rs2_forward_from_wb,
    input  logic                  data_mem_busy,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  pipe_hold,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  rs1_fwd_sel,
    output logic                  rs2_fwd_sel,
    output logic [DATA_WIDTH-1:0] fwd_data
`ifdef STALL_COUNTER_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam logic [2:0] RUN        = 3'd0;
    localparam logic [2:0] LOAD_STALL = 3'd1;
    localparam logic [2:0] FWD        = 3'd2;
    localparam logic [2:0] MEM_WAIT   = 3'd3;
    localparam logic [2:0] FLUSH      = 3'd4;
    logic [2:0]            state_q, state_d, ret_q, ret_d;
    logic                  rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] fwd_q, fwd_d;
    // Next state with busy > branch > bubble; MEM_WAIT remembers which state it interrupted
    always_comb begin
        state_d = RUN;
        ret_d   = ret_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        fwd_d   = fwd_q;
        case (state_q)
            MEM_WAIT: state_d = data_mem_busy ? MEM_WAIT : ret_q;
            LOAD_STALL: begin
                state_d = data_mem_busy ? MEM_WAIT : FWD;
                ret_d   = LOAD_STALL;
                fwd_d   = data_mem_busy ? fwd_q : wb_write_data;
            end
            RUN, FWD, FLUSH: begin
                ret_d = (state_q == FWD) ? FWD : RUN;
                if (data_mem_busy) state_d = MEM_WAIT;
                else if (branch_taken) state_d = FLUSH;
                else if (enable_bubble) begin
                    state_d = LOAD_STALL;
                    rs1_d   = enable_rs1_forward_from_wb;
                    rs2_d   = enable_rs2_forward_from_wb;
                end
            end
            default: state_d = RUN;
        endcase
    end
    // State, resume target, latched forward requests and captured WB data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ret_q   <= RUN;
            rs1_q   <= 1'b0;
            rs2_q   <= 1'b0;
            fwd_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            fwd_q   <= fwd_d;
        end
    end
    assign pc_write_en   = !(state_q == LOAD_STALL || state_q == MEM_WAIT);
    assign ifid_write_en = pc_write_en;
    assign pipe_hold     = state_q == MEM_WAIT;
    assign ifid_flush    = state_q == FLUSH;
    assign idex_bubble   = state_q == LOAD_STALL || state_q == FLUSH;
    assign rs1_fwd_sel   = state_q == FWD && rs1_q;
    assign rs2_fwd_sel   = state_q == FWD && rs2_q;
    assign fwd_data      = fwd_q;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt_q;
    // Count every cycle the PC is frozen; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else if (!pc_write_en) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cycles = stall_cnt_q;
`endif
endmodule

// File: tb/tb_stall_bubble_controller.sv
// tb_stall_bubble_controller: directed stimulus checked every cycle against a queue-based behavioural model.
module tb_stall_bubble_controller;
    localparam int DW = 32;
    logic          clk = 1'b0, reset = 1'b1;
    logic          bub = 1'b0, r1 = 1'b0, r2 = 1'b0, busy = 1'b0, br = 1'b0;
    logic [DW-1:0] wb = '0;
    logic          pc_we, ifid_we, hold, flush, idex_b, s1, s2;
    logic [DW-1:0] fdata;
`ifdef STALL_COUNTER_EN
    logic [31:0]   scyc;
`endif
    int checks = 0, errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    stall_bubble_controller #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .enable_bubble(bub),
        .enable_rs1_forward_from_wb(r1), .enable_rs2_forward_from_wb(r2),
        .data_mem_busy(busy), .branch_taken(br), .wb_write_data(wb),
        .pc_write_en(pc_we), .ifid_write_en(ifid_we), .pipe_hold(hold),
        .ifid_flush(flush), .idex_bubble(idex_b),
        .rs1_fwd_sel(s1), .rs2_fwd_sel(s2), .fwd_data(fdata)
`ifdef STALL_COUNTER_EN
        , .stall_cycles(scyc)
`endif
    );

    typedef enum {M_RUN, M_STALL, M_FWD, M_HOLD, M_FLUSH} mode_t;
    mode_t         cur = M_RUN;
    mode_t         resume[$];
    bit            m_r1, m_r2;
    logic [DW-1:0] m_data = '0;
    logic [31:0]   m_cnt = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
        end
    endtask

    // Model: what the pipe must look like next cycle, given the inputs seen at this edge
    always @(posedge clk) begin
        if (reset) begin
            cur = M_RUN;
            resume.delete();
            m_r1 = 0;
            m_r2 = 0;
            m_data = '0;
            m_cnt = '0;
        end else begin
            if (cur == M_STALL || cur == M_HOLD) m_cnt = m_cnt + 32'd1;
            if (busy) begin
                if (cur == M_STALL || cur == M_FWD) resume.push_back(cur);
                cur = M_HOLD;
            end else if (cur == M_HOLD) cur = (resume.size() != 0) ? resume.pop_front() : M_RUN;
            else if (cur == M_STALL) begin
                m_data = wb;
                cur = M_FWD;
            end else if (br) cur = M_FLUSH;
            else if (bub) begin
                cur = M_STALL;
                m_r1 = r1;
                m_r2 = r2;
            end else cur = M_RUN;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc_write_en", pc_we, cur inside {M_RUN, M_FWD, M_FLUSH});
            chk("ifid_write_en", ifid_we, cur inside {M_RUN, M_FWD, M_FLUSH});
            chk("pipe_hold", hold, cur == M_HOLD);
            chk("ifid_flush", flush, cur == M_FLUSH);
            chk("idex_bubble", idex_b, cur inside {M_STALL, M_FLUSH});
            chk("rs1_fwd_sel", s1, cur == M_FWD && m_r1);
            chk("rs2_fwd_sel", s2, cur == M_FWD && m_r2);
            chk("fwd_data", fdata, m_data);
`ifdef STALL_COUNTER_EN
            chk("stall_cycles", scyc, m_cnt);
`endif
        end
    end

    task automatic drv(input logic b, input logic a1, input logic a2, input logic bs, input logic bt,
                       input logic [DW-1:0] d);
        bub = b; r1 = a1; r2 = a2; busy = bs; br = bt; wb = d;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        chk("rst_pc", pc_we, 1); chk("rst_ifid", ifid_we, 1); chk("rst_hold", hold, 0);
        chk("rst_flush", flush, 0); chk("rst_bubble", idex_b, 0); chk("rst_s1", s1, 0);
        chk("rst_s2", s2, 0); chk("rst_fdata", fdata, 0);
        // load-use stall then rs2 forward
        drv(1, 0, 1, 0, 0, 0);
        chk("ls_bubble", idex_b, 1); chk("ls_pc", pc_we, 0); chk("ls_ifid", ifid_we, 0);
        drv(0, 0, 0, 0, 0, 32'hDEADBEEF);
        chk("fwd_s2", s2, 1); chk("fwd_s1", s1, 0); chk("fwd_data", fdata, 32'hDEADBEEF);
        chk("fwd_pc", pc_we, 1); chk("model_data", m_data, 32'hDEADBEEF);
        drv(0, 0, 0, 0, 0, 0);
        chk("after_fwd_s2", s2, 0); chk("after_fwd_data", fdata, 32'hDEADBEEF);
        // branch beats simultaneous bubble
        drv(1, 1, 1, 0, 1, 0);
        chk("br_flush", flush, 1); chk("br_bubble", idex_b, 1); chk("br_pc", pc_we, 1);
        chk("br_s1", s1, 0); chk("br_s2", s2, 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("br_after_flush", flush, 0); chk("br_no_stall", idex_b, 0);
        // memory busy for 3 cycles starting in LOAD_STALL
        drv(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 1, 0, 0);
            chk("mw_hold", hold, 1);
        end
        drv(0, 0, 0, 0, 0, 32'h11111111);
        chk("mw_resume_ls", idex_b, 1); chk("mw_resume_hold", hold, 0);
        drv(0, 0, 0, 0, 0, 32'hCAFEF00D);
        chk("mw_fwd_s1", s1, 1); chk("mw_fwd_s2", s2, 1); chk("mw_fwd_data", fdata, 32'hCAFEF00D);
        drv(0, 0, 0, 0, 0, 0);
        // memory busy during FWD keeps selects and data
        drv(1, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 32'h55AA55AA);
        drv(0, 0, 0, 1, 0, 0);
        chk("fwdw_s1_hidden", s1, 0); chk("fwdw_hold", hold, 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("fwdw_s1", s1, 1); chk("fwdw_data", fdata, 32'h55AA55AA);
        drv(0, 0, 0, 0, 0, 0);
        // busy beats branch and bubble from RUN
        drv(1, 0, 0, 1, 1, 0);
        chk("prio_hold", hold, 1); chk("prio_flush", flush, 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("prio_pc", pc_we, 1); chk("prio_bubble", idex_b, 0);
        // branch ignored in LOAD_STALL, honoured in FWD
        drv(1, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 32'h00000077);
        chk("brls_s2", s2, 1);
        drv(0, 0, 0, 0, 1, 0);
        chk("brfwd_flush", flush, 1); chk("brfwd_s2", s2, 0);
        drv(0, 0, 0, 0, 0, 0);
        // back-to-back load-use stalls
        drv(1, 1, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 32'hA5A5A5A5);
        chk("b2b_s1", s1, 1);
        drv(1, 0, 1, 0, 0, 0);
        chk("b2b_ls", idex_b, 1);
        drv(0, 0, 0, 0, 0, 32'h0BADF00D);
        chk("b2b_s1b", s1, 0); chk("b2b_s2b", s2, 1); chk("b2b_data", fdata, 32'h0BADF00D);
        drv(0, 0, 0, 0, 0, 0);
        // reset during MEM_WAIT
        drv(0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        drv(0, 0, 0, 1, 0, 0);
        chk("rmw_pc", pc_we, 1); chk("rmw_hold", hold, 0); chk("rmw_data", fdata, 0);
`ifdef STALL_COUNTER_EN
        chk("rmw_cnt", scyc, 0);
`endif
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        // reset during LOAD_STALL leaves no forward behind
        drv(1, 1, 1, 0, 0, 0);
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 32'h0000ABCD);
        chk("rls_bubble", idex_b, 0);
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 32'h0000ABCD);
        chk("rls_s1", s1, 0); chk("rls_s2", s2, 0); chk("rls_data", fdata, 0);
        // patterned mix of all requests
        for (int i = 0; i < 80; i++)
            drv(i % 3 == 0, i[0], i[1], i % 7 == 3, i % 5 == 1, i * 32'h01010101);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
`ifdef STALL_COUNTER_EN
        force dut.stall_cnt_q = 32'hFFFFFFFE;
        m_cnt = 32'hFFFFFFFE;
        #1 release dut.stall_cnt_q;
        drv(0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("cnt_wrap", scyc, 32'h00000000);
`endif
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
